// File: rtl/wb_timer_irq.sv
// Wishbone timer peripheral: prescaled 32-bit counter with compare match,
// one-shot / auto-reload modes and a level interrupt cleared by W1C or EOI.
module wb_timer_irq #(
    parameter int unsigned PRESCALE_W  = 16,
    parameter logic [31:0] RST_COMPARE = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [31:0] i_wb_addr,
    input  logic [31:0] i_wb_data,
    input  logic [3:0]  i_wb_sel,
    output logic        o_wb_stall,
    output logic        o_wb_ack,
    output logic [31:0] o_wb_data,
    input  logic        i_eoi,
    output logic        o_irq
);

    logic [2:0]            ctrl_q, ctrl_d;
    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
    logic [31:0]           count_q, count_d;
    logic [31:0]           cmp_q, cmp_d;
    logic                  pend_q, pend_d;
    logic                  ack_q, ack_d;
    logic [31:0]           rdata_q, rdata_d;

    logic        accept, wr;
    logic [2:0]  slot;
    logic [31:0] lane_mask;
    logic [31:0] presc_ext;
    logic [31:0] presc_wr;
    logic [31:0] rmux;
    logic        tick, match, pend_clr;
    logic        unused_addr;

    assign unused_addr = ^{i_wb_addr[31:5], i_wb_addr[1:0]};

    assign accept    = i_wb_cyc & i_wb_stb & ~ack_q;
    assign wr        = accept & i_wb_we;
    assign slot      = i_wb_addr[4:2];
    assign lane_mask = {{8{i_wb_sel[3]}}, {8{i_wb_sel[2]}}, {8{i_wb_sel[1]}}, {8{i_wb_sel[0]}}};

    always_comb begin
        presc_ext                   = '0;
        presc_ext[PRESCALE_W-1:0]   = presc_q;
    end

    assign presc_wr = (presc_ext & ~lane_mask) | (i_wb_data & lane_mask);

    always_comb begin
        rmux = '0;
        case (slot)
            3'd0:    rmux = {29'd0, ctrl_q};
            3'd1:    rmux = presc_ext;
            3'd2:    rmux = count_q;
            3'd3:    rmux = cmp_q;
            3'd4:    rmux = {31'd0, pend_q};
            default: rmux = '0;
        endcase
    end

    assign tick     = ctrl_q[0] & (pcnt_q == presc_q);
    assign match    = tick & (count_q == cmp_q);
    assign pend_clr = i_eoi | (wr & (slot == 3'd4) & i_wb_sel[0] & i_wb_data[0]);

    always_comb begin
        ctrl_d  = ctrl_q;
        presc_d = presc_q;
        pcnt_d  = pcnt_q;
        count_d = count_q;
        cmp_d   = cmp_q;
        pend_d  = match | (pend_q & ~pend_clr);
        ack_d   = accept;
        rdata_d = accept ? rmux : '0;

        if (!ctrl_q[0] || tick) begin
            pcnt_d = '0;
        end else begin
            pcnt_d = pcnt_q + 1'b1;
        end

        if (tick) begin
            if (match) begin
                if (ctrl_q[1]) begin
                    count_d = '0;
                end else begin
                    ctrl_d[0] = 1'b0;
                end
            end else begin
                count_d = count_q + 32'd1;
            end
        end

        // CPU writes are applied last so they override timer-side updates
        if (wr) begin
            case (slot)
                3'd0: ctrl_d  = ((ctrl_q & ~lane_mask[2:0]) | (i_wb_data[2:0] & lane_mask[2:0]));
                3'd1: presc_d = presc_wr[PRESCALE_W-1:0];
                3'd2: begin
                    count_d = (count_q & ~lane_mask) | (i_wb_data & lane_mask);
                    pcnt_d  = '0;
                end
                3'd3: cmp_d   = (cmp_q & ~lane_mask) | (i_wb_data & lane_mask);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q  <= '0;
            presc_q <= '0;
            pcnt_q  <= '0;
            count_q <= '0;
            cmp_q   <= RST_COMPARE;
            pend_q  <= 1'b0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            presc_q <= presc_d;
            pcnt_q  <= pcnt_d;
            count_q <= count_d;
            cmp_q   <= cmp_d;
            pend_q  <= pend_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
        end
    end

    assign o_wb_stall = 1'b0;
    assign o_wb_ack   = ack_q;
    assign o_wb_data  = rdata_q;
    assign o_irq      = pend_q & ctrl_q[2];

endmodule

// File: tb/tb_wb_timer_irq.sv
// Randomised and directed bench for wb_timer_irq: a cycle-level reference model
// fills a scoreboard queue that a separate monitor drains on every ack.
module tb_wb_timer_irq;

    logic        clk;
    logic        rst_n;
    logic        i_wb_cyc, i_wb_stb, i_wb_we;
    logic [31:0] i_wb_addr, i_wb_data;
    logic [3:0]  i_wb_sel;
    logic        o_wb_stall, o_wb_ack;
    logic [31:0] o_wb_data;
    logic        i_eoi;
    logic        o_irq;

    wb_timer_irq #(
        .PRESCALE_W  (16),
        .RST_COMPARE (32'hFFFF_FFFF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_wb_cyc   (i_wb_cyc),
        .i_wb_stb   (i_wb_stb),
        .i_wb_we    (i_wb_we),
        .i_wb_addr  (i_wb_addr),
        .i_wb_data  (i_wb_data),
        .i_wb_sel   (i_wb_sel),
        .o_wb_stall (o_wb_stall),
        .o_wb_ack   (o_wb_ack),
        .o_wb_data  (o_wb_data),
        .i_eoi      (i_eoi),
        .o_irq      (o_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { bit rd; logic [31:0] data; } exp_t;
    exp_t exp_q[$];

    logic [2:0]  m_ctrl;
    logic [31:0] m_presc, m_pcnt, m_count, m_cmp;
    bit          m_pend, m_ack;

    function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [31:0] d,
                                               input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] slot_value(input int unsigned a);
        case (a)
            0: return {29'd0, m_ctrl};
            1: return m_presc;
            2: return m_count;
            3: return m_cmp;
            4: return {31'd0, m_pend};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_ctrl = '0; m_presc = '0; m_pcnt = '0; m_count = '0;
        m_cmp = 32'hFFFF_FFFF; m_pend = 0; m_ack = 0;
        exp_q.delete();
    endtask

    task automatic model_step();
        bit          acc, wr, tick, hit, clr;
        int unsigned a;
        logic [2:0]  n_ctrl;
        logic [31:0] n_pcnt, n_count, wv;
        exp_t        e;
        acc = i_wb_cyc && i_wb_stb && !m_ack;
        wr  = acc && i_wb_we;
        a   = i_wb_addr[4:2];
        if (acc) begin
            e.rd = !i_wb_we;
            e.data = slot_value(a);
            exp_q.push_back(e);
        end
        tick = m_ctrl[0] && (m_pcnt == m_presc);
        hit  = tick && (m_count == m_cmp);
        clr  = i_eoi || (wr && a == 4 && i_wb_sel[0] && i_wb_data[0]);
        n_pcnt  = (!m_ctrl[0] || tick) ? 32'd0 : m_pcnt + 32'd1;
        n_count = m_count;
        n_ctrl  = m_ctrl;
        if (tick) begin
            if (!hit) n_count = m_count + 32'd1;
            else if (m_ctrl[1]) n_count = 32'd0;
            else n_ctrl[0] = 1'b0;
        end
        m_pend = hit ? 1'b1 : (clr ? 1'b0 : m_pend);
        if (wr) begin
            case (a)
                0: begin wv = lane_merge({29'd0, m_ctrl}, i_wb_data, i_wb_sel); n_ctrl = wv[2:0]; end
                1: m_presc = lane_merge(m_presc, i_wb_data, i_wb_sel) & 32'h0000_FFFF;
                2: begin n_count = lane_merge(m_count, i_wb_data, i_wb_sel); n_pcnt = 32'd0; end
                3: m_cmp = lane_merge(m_cmp, i_wb_data, i_wb_sel);
                default: ;
            endcase
        end
        m_ctrl = n_ctrl; m_pcnt = n_pcnt; m_count = n_count;
        m_ack = acc;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            chk("stall", {31'd0, o_wb_stall}, 32'd0);
            chk("ack", {31'd0, o_wb_ack}, {31'd0, m_ack});
            chk("irq", {31'd0, o_irq}, {31'd0, m_pend && m_ctrl[2]});
            if (m_ack) begin
                if (exp_q.size() == 0) begin
                    chk("sb_underflow", 32'd1, {31'd0, o_wb_ack});
                end else begin
                    e = exp_q.pop_front();
                    if (e.rd && o_wb_ack) chk("rdata", o_wb_data, e.data);
                end
            end else begin
                chk("idle_data", o_wb_data, 32'd0);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic bus(input logic we, input logic [2:0] slot, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] rd);
        i_wb_cyc = 1; i_wb_stb = 1; i_wb_we = we;
        i_wb_addr = {27'd0, slot, 2'b00}; i_wb_data = d; i_wb_sel = s;
        @(posedge clk); #1;
        i_wb_cyc = 0; i_wb_stb = 0; i_wb_we = 0;
        chk("ack_latency", {31'd0, o_wb_ack}, 32'd1);
        rd = o_wb_data;
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [2:0] slot, input logic [31:0] d);
        logic [31:0] unused_rd;
        bus(1'b1, slot, d, 4'hF, unused_rd);
    endtask

    task automatic wr_sel(input logic [2:0] slot, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] unused_rd;
        bus(1'b1, slot, d, s, unused_rd);
    endtask

    task automatic rd_chk(input string name, input logic [2:0] slot, input logic [31:0] exp);
        logic [31:0] v;
        bus(1'b0, slot, 32'd0, 4'hF, v);
        chk(name, v, exp);
    endtask

    task automatic rd_any(input logic [2:0] slot);
        logic [31:0] unused_rd;
        bus(1'b0, slot, 32'd0, 4'hF, unused_rd);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [31:0] reset_vals [8];

    initial begin
        int n;
        reset_vals = '{32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0};
        rst_n = 0; i_wb_cyc = 0; i_wb_stb = 0; i_wb_we = 0;
        i_wb_addr = '0; i_wb_data = '0; i_wb_sel = '0; i_eoi = 0;
        idle(3);
        rst_n = 1;
        idle(1);

        for (int i = 0; i < 8; i++) rd_chk("reset_read", 3'(i), reset_vals[i]);
        chk("reset_irq", {31'd0, o_irq}, 32'd0);

        // auto-reload with prescaler
        wr(1, 3); wr(3, 2); wr(2, 0); wr(0, 7);
        for (int i = 0; i < 8; i++) begin rd_any(2); idle(1); end
        idle(20);

        // W1C, then EOI on the next interrupt
        wr(4, 1);
        n = 0;
        while (o_irq !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
        chk("irq_rearm", {31'd0, o_irq}, 32'd1);
        i_eoi = 1; @(posedge clk); #1; i_eoi = 0;
        chk("eoi_clears", {31'd0, o_irq}, 32'd0);

        // clear held on every cycle while matches keep arriving
        wr(1, 0); wr(3, 3); wr(2, 0); wr(0, 7);
        i_eoi = 1; idle(20); i_eoi = 0;
        idle(2);

        // one-shot
        wr(0, 0); wr(4, 1); wr(1, 0); wr(2, 0); wr(3, 5); wr(0, 5);
        idle(12);
        rd_chk("oneshot_ctrl", 0, 32'd4);
        rd_chk("oneshot_count", 2, 32'd5);
        rd_chk("oneshot_pend", 4, 32'd1);
        idle(10);
        rd_chk("oneshot_hold", 2, 32'd5);

        // byte lanes and out-of-width bits
        wr(3, 0);
        wr_sel(3, 32'h0000_AB00, 4'b0010);
        rd_chk("lane_cmp", 3, 32'h0000_AB00);
        wr_sel(3, 32'hFFFF_FFFF, 4'b1000);
        rd_chk("lane_cmp_hi", 3, 32'hFF00_AB00);
        wr(1, 32'hFFFF_FFFF);
        rd_chk("presc_width", 1, 32'h0000_FFFF);
        wr(0, 32'hFFFF_FFF8);
        rd_chk("ctrl_width", 0, 32'd0);
        wr(5, 32'hFFFF_FFFF);
        rd_chk("reserved", 5, 32'd0);

        // COUNT writes landing on each prescaler phase
        wr(1, 3); wr(3, 1000); wr(2, 0); wr(0, 3);
        for (int p = 0; p < 4; p++) begin
            idle(p);
            wr(2, 32'h100 * (p + 1));
            rd_any(2);
        end

        // asynchronous reset during an accepted access
        wr(0, 0); wr(2, 0); wr(1, 0); wr(3, 0); wr(0, 5);
        idle(3);
        wr(2, 7);
        chk("irq_before_reset", {31'd0, o_irq}, 32'd1);
        i_wb_cyc = 1; i_wb_stb = 1; i_wb_we = 0; i_wb_addr = 32'h8;
        @(posedge clk); #3;
        rst_n = 0; i_wb_cyc = 0; i_wb_stb = 0;
        #1;
        chk("rst_ack", {31'd0, o_wb_ack}, 32'd0);
        chk("rst_data", o_wb_data, 32'd0);
        chk("rst_irq", {31'd0, o_irq}, 32'd0);
        @(posedge clk); #1;
        chk("rst_no_ack", {31'd0, o_wb_ack}, 32'd0);
        @(posedge clk); #2;
        rst_n = 1;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) rd_chk("post_reset_read", 3'(i), reset_vals[i]);

        // randomised traffic
        repeat (400) begin
            i_wb_cyc  = ($urandom_range(0, 4) != 0);
            i_wb_stb  = ($urandom_range(0, 3) != 0);
            i_wb_we   = $urandom_range(0, 1);
            i_wb_addr = $urandom;
            i_wb_data = ($urandom_range(0, 1) != 0) ? $urandom : $urandom_range(0, 6);
            i_wb_sel  = 4'($urandom_range(0, 15));
            i_eoi     = ($urandom_range(0, 9) == 0);
            @(posedge clk); #1;
        end
        i_wb_cyc = 0; i_wb_stb = 0; i_wb_we = 0; i_eoi = 0;
        idle(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
